fmul_float_arbiter: RTL and testbench

Shares one fmul_float pipeline between NUM_REQ independent requesters. A round-robin arbiter selects one requester per accepted issue. A tag FIFO records the requester index of every operation in flight, and each result is routed back to the requester that issued it. The block sits between the requester-side REQ/BUSY and VALID/BUSY channels and the fmul_float input and output channels, and propagates backpressure in both directions.

---
 rtl/fmul_float_arbiter_if.sv | 35 +++
 rtl/fmul_float_arbiter.sv | 137 +++++++++++++
 tb/tb_fmul_float_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_float_arbiter_if.sv
// Requester-side and fmul-side channels of fmul_float_arbiter, bundled for port binding.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface fmul_float_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3
);
  logic [NUM_REQ-1:0]    iREQ_REQ;
  logic [NUM_REQ-1:0]    oREQ_BUSY;
  logic [NUM_REQ*32-1:0] iREQ_A;
  logic [NUM_REQ*32-1:0] iREQ_B;
  logic [NUM_REQ-1:0]    oRES_VALID;
  logic [NUM_REQ-1:0]    iRES_BUSY;
  logic [31:0]           oRES_DATA;
  logic                  oFMUL_REQ;
  logic                  iFMUL_BUSY;
  logic [31:0]           oFMUL_A;
  logic [31:0]           oFMUL_B;
  logic                  iFMUL_VALID;
  logic                  oFMUL_BUSY;
  logic [31:0]           iFMUL_DATA;
  logic [TAG_W:0]        oINFLIGHT;
  logic                  oERROR;

  modport slave (
    input  iREQ_REQ, iREQ_A, iREQ_B, iRES_BUSY, iFMUL_BUSY, iFMUL_VALID, iFMUL_DATA,
    output oREQ_BUSY, oRES_VALID, oRES_DATA, oFMUL_REQ, oFMUL_A, oFMUL_B, oFMUL_BUSY,
           oINFLIGHT, oERROR
  );

  modport master (
    output iREQ_REQ, iREQ_A, iREQ_B, iRES_BUSY, iFMUL_BUSY, iFMUL_VALID, iFMUL_DATA,
    input  oREQ_BUSY, oRES_VALID, oRES_DATA, oFMUL_REQ, oFMUL_A, oFMUL_B, oFMUL_BUSY,
           oINFLIGHT, oERROR
  );
endinterface

// File: rtl/fmul_float_arbiter.sv
// Round-robin sharing of one in-order fmul_float pipeline between NUM_REQ requesters;
// a tag FIFO remembers who issued each in-flight operation so results route back.
module fmul_float_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_W     = 2,
  parameter int TAG_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  fmul_float_arbiter_if.slave  bus
);

  // Handshake: every channel transfers on a rising edge where REQ/VALID=1 and BUSY=0;
  // the sender keeps REQ/VALID and its data stable while BUSY is 1.

  logic                 in_reset;
  logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [TAG_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [TAG_W:0]       count_q, count_d;
  logic                 error_q, error_d;
  logic [REQ_W-1:0]     tag_q [TAG_DEPTH];
  logic [REQ_W-1:0]     tag_d [TAG_DEPTH];

  logic [REQ_W:0]       scan_idx;
  logic [REQ_W-1:0]     grant;
  logic                 grant_found;
  logic                 stall;
  logic                 empty;
  logic [REQ_W-1:0]     head;
  logic                 fmul_req;
  logic                 fmul_busy;
  logic                 issue;
  logic                 pop;

  assign in_reset = !inRESET || iRESET_SYNC;

  // Scan from the round-robin pointer upward, wrapping at NUM_REQ.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (REQ_W+1)'(k);
      if (scan_idx >= (REQ_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (REQ_W+1)'(NUM_REQ);
      end
      if (!grant_found && bus.iREQ_REQ[scan_idx[REQ_W-1:0]]) begin
        grant       = scan_idx[REQ_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  assign stall     = (count_q == (TAG_W+1)'(TAG_DEPTH));
  assign empty     = (count_q == '0);
  assign head      = tag_q[rd_ptr_q];
  assign fmul_req  = grant_found && !stall && !in_reset;
  assign fmul_busy = in_reset || empty || bus.iRES_BUSY[head];
  assign issue     = fmul_req && !bus.iFMUL_BUSY;
  assign pop       = bus.iFMUL_VALID && !fmul_busy;

  always_comb begin
    bus.oFMUL_REQ  = fmul_req;
    bus.oFMUL_BUSY = fmul_busy;
    bus.oFMUL_A    = '0;
    bus.oFMUL_B    = '0;
    if (grant_found) begin
      bus.oFMUL_A = bus.iREQ_A[grant*32 +: 32];
      bus.oFMUL_B = bus.iREQ_B[grant*32 +: 32];
    end
    bus.oRES_DATA  = bus.iFMUL_DATA;
    bus.oINFLIGHT  = in_reset ? '0 : count_q;
    bus.oERROR     = error_q;
    bus.oREQ_BUSY  = '1;
    bus.oRES_VALID = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      bus.oREQ_BUSY[n]  = in_reset || !(grant_found && (grant == REQ_W'(n)))
                          || bus.iFMUL_BUSY || stall;
      bus.oRES_VALID[n] = !in_reset && bus.iFMUL_VALID && !empty && (head == REQ_W'(n));
    end
  end

  // A pop in the same cycle does not lift the full stall; stall uses count_q.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    tag_d    = tag_q;
    if (issue) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      rr_ptr_d        = (grant == REQ_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({issue, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.iFMUL_VALID && empty) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      tag_q    <= '{default: '0};
    end else if (iRESET_SYNC) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      tag_q    <= '{default: '0};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_fmul_float_arbiter.sv
// Directed bench for fmul_float_arbiter; the bench itself plays a 3-cycle in-order fmul.
module tb_fmul_float_arbiter;

  localparam int          LAT = 3;
  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic iCLOCK;
  logic inRESET;
  logic iRESET_SYNC;

  fmul_float_arbiter_if #(.NUM_REQ(4), .TAG_W(3)) bus ();

  fmul_float_arbiter #(.NUM_REQ(4), .REQ_W(2), .TAG_DEPTH(8), .TAG_W(3)) dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .bus         (bus)
  );

  // clock / reset
  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  int tests_run;
  int tests_failed;
  int cyc;
  int k_cnt [4];

  // fake fmul pipeline and scoreboard
  logic [31:0] pipe_data [$];
  int          pipe_t    [$];
  logic [31:0] exp_q     [$];
  int          exp_dst_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int n);
    logic [3:0] r;
    r    = '0;
    r[n] = 1'b1;
    return r;
  endfunction

  // x * 1.0 == x for these normal floats, so A is also the expected product
  function automatic logic [31:0] op_a(input int n, input int k);
    return 32'(32'h0100_0000 * (n + 1) + k);
  endfunction

  task automatic drive_ops();
    for (int n = 0; n < 4; n++) begin
      bus.iREQ_A[n*32 +: 32] = op_a(n, k_cnt[n]);
      bus.iREQ_B[n*32 +: 32] = ONE;
    end
    if (pipe_data.size() > 0 && (cyc - pipe_t[0]) >= LAT) begin
      bus.iFMUL_VALID = 1'b1;
      bus.iFMUL_DATA  = pipe_data[0];
    end else begin
      bus.iFMUL_VALID = 1'b0;
      bus.iFMUL_DATA  = '0;
    end
  endtask

  // One clock: exp_g is the requester expected to issue this cycle, -1 for none.
  task automatic tick(input int exp_g);
    logic       exp_pop;
    logic [3:0] exp_busy;
    int         d;
    drive_ops();
    #1;
    exp_pop = 1'b0;
    if (bus.iFMUL_VALID) begin
      d = exp_dst_q[0];
      check("res_valid", bus.oRES_VALID, onehot(d));
      check("res_data", bus.oRES_DATA, exp_q[0]);
      exp_pop = !bus.iRES_BUSY[d];
      check("fmul_busy", bus.oFMUL_BUSY, !exp_pop);
    end
    if (exp_g >= 0) begin
      exp_busy = ~onehot(exp_g);
      check("req_busy", bus.oREQ_BUSY, exp_busy);
      check("fmul_a", bus.oFMUL_A, op_a(exp_g, k_cnt[exp_g]));
    end
    check("issue", bus.oFMUL_REQ && !bus.iFMUL_BUSY, exp_g >= 0);
    @(posedge iCLOCK);
    #1;
    if (exp_g >= 0) begin
      pipe_data.push_back(op_a(exp_g, k_cnt[exp_g]));
      pipe_t.push_back(cyc);
      exp_q.push_back(op_a(exp_g, k_cnt[exp_g]));
      exp_dst_q.push_back(exp_g);
      k_cnt[exp_g]++;
    end
    if (exp_pop) begin
      void'(pipe_data.pop_front());
      void'(pipe_t.pop_front());
      void'(exp_q.pop_front());
      void'(exp_dst_q.pop_front());
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(-1);
    check("drain_left", exp_q.size(), 0);
    check("drain_inflight", bus.oINFLIGHT, 0);
  endtask

  task automatic pulse_sync_reset();
    iRESET_SYNC = 1'b1;
    #1;
    check("srst_req_busy", bus.oREQ_BUSY, 4'hF);
    check("srst_fmul_req", bus.oFMUL_REQ, 0);
    check("srst_res_valid", bus.oRES_VALID, 0);
    check("srst_fmul_busy", bus.oFMUL_BUSY, 1);
    @(posedge iCLOCK);
    #1;
    iRESET_SYNC = 1'b0;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    for (int n = 0; n < 4; n++) k_cnt[n] = 0;
    inRESET         = 1'b0;
    iRESET_SYNC     = 1'b0;
    bus.iREQ_REQ    = 4'hF;
    bus.iREQ_A      = '0;
    bus.iREQ_B      = '0;
    bus.iRES_BUSY   = '0;
    bus.iFMUL_BUSY  = 1'b0;
    bus.iFMUL_VALID = 1'b0;
    bus.iFMUL_DATA  = '0;

    // reset state
    #3;
    check("rst_fmul_req", bus.oFMUL_REQ, 0);
    check("rst_req_busy", bus.oREQ_BUSY, 4'hF);
    check("rst_res_valid", bus.oRES_VALID, 0);
    check("rst_fmul_busy", bus.oFMUL_BUSY, 1);
    check("rst_inflight", bus.oINFLIGHT, 0);
    check("rst_error", bus.oERROR, 0);
    @(posedge iCLOCK);
    #1;
    inRESET      = 1'b1;
    bus.iREQ_REQ = 4'h0;

    // single request from requester 2: 1.5 * 2.0 = 3.0
    bus.iREQ_REQ        = 4'b0100;
    bus.iREQ_A[64 +: 32] = 32'h3FC0_0000;
    bus.iREQ_B[64 +: 32] = 32'h4000_0000;
    #1;
    check("t1_req_busy", bus.oREQ_BUSY, 4'b1011);
    check("t1_fmul_req", bus.oFMUL_REQ, 1);
    check("t1_fmul_a", bus.oFMUL_A, 32'h3FC0_0000);
    check("t1_fmul_b", bus.oFMUL_B, 32'h4000_0000);
    check("t1_inflight0", bus.oINFLIGHT, 0);
    @(posedge iCLOCK);
    #1;
    bus.iREQ_REQ = 4'h0;
    #1;
    check("t1_inflight1", bus.oINFLIGHT, 1);
    check("t1_fmul_req_idle", bus.oFMUL_REQ, 0);
    check("t1_fmul_a_idle", bus.oFMUL_A, 0);
    bus.iFMUL_VALID = 1'b1;
    bus.iFMUL_DATA  = 32'h4040_0000;
    #1;
    check("t1_res_valid", bus.oRES_VALID, 4'b0100);
    check("t1_res_data", bus.oRES_DATA, 32'h4040_0000);
    check("t1_fmul_busy", bus.oFMUL_BUSY, 0);
    @(posedge iCLOCK);
    #1;
    bus.iFMUL_VALID = 1'b0;
    #1;
    check("t1_inflight2", bus.oINFLIGHT, 0);
    check("t1_res_valid_off", bus.oRES_VALID, 0);
    check("t1_error", bus.oERROR, 0);
    @(posedge iCLOCK);
    #1;

    // all requesters, fmul never busy: grants 0,1,2,3,... after pointer reset
    bus.iREQ_REQ = 4'hF;
    pulse_sync_reset();
    for (int i = 0; i < 12; i++) tick(i % 4);
    bus.iREQ_REQ = 4'h0;
    drain();

    // result stall on requester 0 fills the tag FIFO
    pulse_sync_reset();
    bus.iRES_BUSY = 4'b0001;
    bus.iREQ_REQ  = 4'hF;
    for (int i = 0; i < 8; i++) tick(i % 4);
    check("t3_inflight_full", bus.oINFLIGHT, 8);
    check("t3_fmul_req_full", bus.oFMUL_REQ, 0);
    check("t3_req_busy_full", bus.oREQ_BUSY, 4'hF);
    tick(-1);
    tick(-1);
    bus.iRES_BUSY = 4'b0000;
    tick(-1);
    tick(0);
    check("t3_inflight_resume", bus.oINFLIGHT, 7);
    bus.iREQ_REQ = 4'h0;
    drain();

    // fmul busy for 5 cycles: no issue, pointer held
    pulse_sync_reset();
    bus.iREQ_REQ   = 4'b1010;
    bus.iFMUL_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(-1);
      check("t4_req_busy", bus.oREQ_BUSY, 4'hF);
      check("t4_inflight", bus.oINFLIGHT, 0);
    end
    bus.iFMUL_BUSY = 1'b0;
    tick(1);
    tick(3);
    bus.iREQ_REQ = 4'h0;
    drain();

    // stray result with empty FIFO
    bus.iFMUL_VALID = 1'b1;
    bus.iFMUL_DATA  = 32'hDEAD_BEEF;
    #1;
    check("t5_fmul_busy", bus.oFMUL_BUSY, 1);
    check("t5_res_valid", bus.oRES_VALID, 0);
    check("t5_error_before", bus.oERROR, 0);
    @(posedge iCLOCK);
    #1;
    check("t5_error_set", bus.oERROR, 1);
    bus.iFMUL_VALID = 1'b0;
    repeat (3) @(posedge iCLOCK);
    #1;
    check("t5_error_sticky", bus.oERROR, 1);
    check("t5_inflight", bus.oINFLIGHT, 0);
    pulse_sync_reset();
    check("t5_error_clear", bus.oERROR, 0);

    // async reset with 3 operations in flight
    bus.iREQ_REQ = 4'hF;
    tick(0);
    tick(1);
    tick(2);
    drive_ops();
    #1;
    check("t6_inflight3", bus.oINFLIGHT, 3);
    check("t6_res_valid_pre", bus.oRES_VALID, 4'b0001);
    inRESET = 1'b0;
    #1;
    check("t6_inflight_rst", bus.oINFLIGHT, 0);
    check("t6_res_valid_rst", bus.oRES_VALID, 0);
    check("t6_fmul_req_rst", bus.oFMUL_REQ, 0);
    check("t6_req_busy_rst", bus.oREQ_BUSY, 4'hF);
    pipe_data.delete();
    pipe_t.delete();
    exp_q.delete();
    exp_dst_q.delete();
    bus.iFMUL_VALID = 1'b0;
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;
    #1;
    check("t6_ptr_restart", bus.oREQ_BUSY, 4'b1110);
    check("t6_fmul_a", bus.oFMUL_A, op_a(0, k_cnt[0]));
    bus.iREQ_REQ = 4'h0;
    @(posedge iCLOCK);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
